// File: rtl/jtcop_mcu_pkg.sv
// Shared definitions for the Dec0 main-CPU <-> security-MCU mailbox.
// Holds the FSM encoding, the MCU register map and the status bit layout.
package jtcop_mcu_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_RAISE = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    REG_CMDL = 2'd0,
    REG_CMDH = 2'd1,
    REG_STAT = 2'd2,
    REG_REPH = 2'd3
  } reg_addr_t;

  localparam int STAT_INT  = 0;
  localparam int STAT_SEC2 = 1;
  localparam int STAT_OVR  = 2;

  function automatic logic [7:0] status_byte(input logic ovr, input logic sec2,
                                             input logic int_pend);
    logic [7:0] s;
    s            = 8'h00;
    s[STAT_OVR]  = ovr;
    s[STAT_SEC2] = sec2;
    s[STAT_INT]  = int_pend;
    return s;
  endfunction

endpackage

// File: rtl/jtcop_mcu_edge.sv
// Registered rising-edge detector for the main CPU sec[] strobes.
// Reset reloads both stages with the live level so a strobe held through reset never fires.
module jtcop_mcu_edge (
  input  logic clk,
  input  logic rst,
  input  logic strobe,
  output logic rise
);

  logic s1;
  logic s2;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= strobe;
      s2 <= strobe;
    end else begin
      s1 <= strobe;
      s2 <= s1;
    end
  end

  assign rise = s1 & ~s2;

endmodule

// File: rtl/jtcop_mcu_mailbox.sv
// MCU-side mailbox: command capture, reply latch and sec2 interrupt to the main 68000.
// Define JTCOP_MCU_TIMEOUT_EN to force sec2 low after TOUT unread cycles.
module jtcop_mcu_mailbox
  import jtcop_mcu_pkg::*;
`ifdef JTCOP_MCU_TIMEOUT_EN
#(
  parameter logic [23:0] TOUT = 24'd800000
)
`endif
(
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] main_dout,
  input  logic        main_wr,
  input  logic        main_rd,
  output logic [15:0] mcu_dout,
  output logic        sec2,
  input  logic [1:0]  mcu_addr,
  input  logic        mcu_we,
  input  logic        mcu_re,
  input  logic [7:0]  mcu_din,
  output logic [7:0]  mcu_q,
  output logic        mcu_intn
);

  logic        wr_ev;
  logic        rd_ev;
  logic [15:0] cmd;
  logic [7:0]  rep;
  logic        ovr;
  logic        rearm;
  logic        rearm_nx;
  logic        sec2_nx;
  logic        timeout;
  logic [7:0]  rd_data;
  state_t      state;
  state_t      state_nx;

  jtcop_mcu_edge u_wr_edge (.clk(clk), .rst(rst), .strobe(main_wr), .rise(wr_ev));
  jtcop_mcu_edge u_rd_edge (.clk(clk), .rst(rst), .strobe(main_rd), .rise(rd_ev));

  wire wr_rep   = mcu_we && (mcu_addr == REG_REPH);
  wire wr_repl  = mcu_we && (mcu_addr == REG_STAT);
  wire rd_cmdl  = mcu_re && (mcu_addr == REG_CMDL);
  wire rd_stat  = mcu_re && (mcu_addr == REG_STAT);

`ifdef JTCOP_MCU_TIMEOUT_EN
  logic [23:0] tcnt;

  // A fresh reply restarts the unread window, including a rewrite while already raised.
  always_ff @(posedge clk) begin
    if (rst || state == ST_IDLE || wr_rep) tcnt <= 24'd0;
    else                                   tcnt <= tcnt + 24'd1;
  end

  assign timeout = (state == ST_RAISE) && !wr_rep && (tcnt == TOUT - 24'd1);
`else
  assign timeout = 1'b0;
`endif

  // NOTE: every signal written here gets a default first, so no latch is inferred.
  always_comb begin
    state_nx = state;
    sec2_nx  = sec2;
    rearm_nx = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (wr_rep) begin
          state_nx = ST_RAISE;
          sec2_nx  = 1'b1;
        end
      end
      ST_RAISE: begin
        if (wr_rep && rd_ev) begin
          // Drop for one cycle so the main CPU sees a new edge for the new reply.
          sec2_nx  = 1'b0;
          rearm_nx = 1'b1;
        end else if (wr_rep) begin
          sec2_nx = 1'b1;
        end else if (rd_ev || timeout) begin
          state_nx = ST_IDLE;
          sec2_nx  = 1'b0;
        end else if (rearm) begin
          sec2_nx = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      sec2  <= 1'b0;
      rearm <= 1'b0;
    end else begin
      state <= state_nx;
      sec2  <= sec2_nx;
      rearm <= rearm_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cmd      <= 16'h0000;
      rep      <= 8'h00;
      mcu_dout <= 16'h0000;
      mcu_intn <= 1'b1;
      ovr      <= 1'b0;
    end else begin
      if (wr_ev)   cmd      <= main_dout;
      if (wr_repl) rep      <= mcu_din;
      if (wr_rep)  mcu_dout <= {mcu_din, rep};
      // A new command beats a concurrent low-byte read: the interrupt stays asserted.
      if (wr_ev)        mcu_intn <= 1'b0;
      else if (rd_cmdl) mcu_intn <= 1'b1;
      if ((wr_ev && !mcu_intn) || timeout) ovr <= 1'b1;
      else if (rd_stat)                    ovr <= 1'b0;
    end
  end

  always_comb begin
    rd_data = 8'hff;
    case (mcu_addr)
      REG_CMDL: rd_data = cmd[7:0];
      REG_CMDH: rd_data = cmd[15:8];
      REG_STAT: rd_data = status_byte(ovr, sec2, ~mcu_intn);
      default:  rd_data = 8'hff;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)         mcu_q <= 8'h00;
    else if (mcu_re) mcu_q <= rd_data;
  end

endmodule

// File: tb/tb_jtcop_mcu_mailbox.sv
// Scoreboard bench for jtcop_mcu_mailbox: directed corner cases plus a randomized phase.
// Honours JTCOP_MCU_TIMEOUT_EN (built with TOUT=16 when defined).
module tb_jtcop_mcu_mailbox;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] main_dout;
  logic        main_wr;
  logic        main_rd;
  logic [15:0] mcu_dout;
  logic        sec2;
  logic [1:0]  mcu_addr;
  logic        mcu_we;
  logic        mcu_re;
  logic [7:0]  mcu_din;
  logic [7:0]  mcu_q;
  logic        mcu_intn;

  always #5 clk = ~clk;

`ifdef JTCOP_MCU_TIMEOUT_EN
  jtcop_mcu_mailbox #(.TOUT(24'd16)) dut (.*);
`else
  jtcop_mcu_mailbox dut (.*);
`endif

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model of the mailbox, in terms of what software sees.
  logic [15:0] m_cmd;
  logic [7:0]  m_rep;
  bit          m_pend;
  bit          m_ovr;
  bit          m_raised;

  logic [7:0]  exp_q[$];
  logic [15:0] rep_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_cmd = 16'h0; m_rep = 8'h0; m_pend = 0; m_ovr = 0; m_raised = 0;
  endtask

  function automatic logic [7:0] model_read(input logic [1:0] a);
    case (a)
      2'd0:    return m_cmd[7:0];
      2'd1:    return m_cmd[15:8];
      2'd2:    return {5'b0, m_ovr, m_raised, m_pend};
      default: return 8'hff;
    endcase
  endfunction

  // Monitor: compares mcu_q the cycle after each MCU read, and mcu_dout on each sec2 rise.
  logic re_d = 1'b0;
  logic sec2_prev = 1'b0;
  always @(posedge clk) re_d <= mcu_re;

  always @(negedge clk) begin
    if (re_d) begin
      if (exp_q.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL mcu_q_unexpected: got %0h, expected no read", mcu_q);
      end else begin
        check("mcu_q", 32'(mcu_q), 32'(exp_q.pop_front()));
      end
    end
    if (sec2 && !sec2_prev) begin
      if (rep_q.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL sec2_unexpected_rise: got mcu_dout %0h, expected no rise", mcu_dout);
      end else begin
        check("mcu_dout_at_sec2", 32'(mcu_dout), 32'(rep_q.pop_front()));
      end
    end
    sec2_prev = sec2;
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic main_write(input logic [15:0] d, input int len);
    main_dout = d;
    main_wr   = 1'b1;
    idle(len);
    main_wr   = 1'b0;
    idle(2);
    if (m_pend) m_ovr = 1;
    m_cmd  = d;
    m_pend = 1;
  endtask

  task automatic main_read(input int len);
    main_rd = 1'b1;
    idle(len);
    main_rd = 1'b0;
    idle(2);
    m_raised = 0;
  endtask

  task automatic mcu_read(input logic [1:0] a);
    exp_q.push_back(model_read(a));
    if (a == 2'd0) m_pend = 0;
    if (a == 2'd2) m_ovr  = 0;
    mcu_addr = a;
    mcu_re   = 1'b1;
    idle(1);
    mcu_re   = 1'b0;
  endtask

  task automatic mcu_write(input logic [1:0] a, input logic [7:0] d);
    if (a == 2'd2) m_rep = d;
    if (a == 2'd3) begin
      rep_q.push_back({d, m_rep});
      m_raised = 1;
    end
    mcu_addr = a;
    mcu_din  = d;
    mcu_we   = 1'b1;
    idle(1);
    mcu_we   = 1'b0;
  endtask

  initial begin
    int cnt;
    rst = 1'b1; main_dout = 16'h0; main_wr = 1'b0; main_rd = 1'b0;
    mcu_addr = 2'd0; mcu_we = 1'b0; mcu_re = 1'b0; mcu_din = 8'h0;
    model_reset();
    idle(3);
    check("reset_mcu_dout", 32'(mcu_dout), 32'h0);
    check("reset_sec2", 32'(sec2), 32'h0);
    check("reset_mcu_q", 32'(mcu_q), 32'h0);
    check("reset_mcu_intn", 32'(mcu_intn), 32'h1);
    rst = 1'b0;
    idle(1);

    // Long strobe yields a single command event.
    main_write(16'h1234, 3);
    check("intn_after_cmd", 32'(mcu_intn), 32'h0);
    mcu_read(2'd0);
    check("intn_after_cmdl_rd", 32'(mcu_intn), 32'h1);
    mcu_read(2'd1);
    mcu_read(2'd2);

    // Reply and interrupt handshake.
    mcu_write(2'd2, 8'hcd);
    mcu_write(2'd3, 8'hab);
    check("sec2_after_reply", 32'(sec2), 32'h1);
    check("mcu_dout_reply", 32'(mcu_dout), 32'habcd);
    main_rd = 1'b1;
    idle(1);
    check("sec2_before_rd_event", 32'(sec2), 32'h1);
    idle(1);
    check("sec2_after_rd_event", 32'(sec2), 32'h0);
    main_rd = 1'b0;
    idle(2);
    m_raised = 0;
    main_read(2);
    check("idle_rd_keeps_dout", 32'(mcu_dout), 32'habcd);
    check("idle_rd_sec2", 32'(sec2), 32'h0);

    // Overrun is sticky until the status read.
    main_write(16'h0001, 2);
    main_write(16'h0002, 1);
    mcu_read(2'd2);
    mcu_read(2'd2);
    mcu_read(2'd0);
    mcu_read(2'd1);

    // Reply write colliding with a main read event while raised.
    mcu_write(2'd3, 8'h55);
    main_rd = 1'b1;
    idle(1);
    mcu_addr = 2'd3; mcu_din = 8'h77; mcu_we = 1'b1;
    rep_q.push_back({8'h77, m_rep});
    check("collide_seq_1", 32'(sec2), 32'h1);
    idle(1);
    mcu_we = 1'b0;
    check("collide_seq_0", 32'(sec2), 32'h0);
    idle(1);
    check("collide_seq_1b", 32'(sec2), 32'h1);
    check("collide_dout", 32'(mcu_dout), 32'h77cd);
    main_rd = 1'b0;
    idle(2);
    main_read(1);
    check("sec2_cleared", 32'(sec2), 32'h0);

    // New command colliding with a low-byte read.
    main_dout = 16'hbeef; main_wr = 1'b1;
    idle(1);
    mcu_addr = 2'd0; mcu_re = 1'b1;
    exp_q.push_back(m_cmd[7:0]);
    idle(1);
    mcu_re = 1'b0; main_wr = 1'b0;
    idle(2);
    m_cmd = 16'hbeef; m_pend = 1;
    check("collide_intn", 32'(mcu_intn), 32'h0);
    mcu_read(2'd1);
    mcu_read(2'd2);

    // Reset while raised with main_rd held; strobe held through release must not fire.
    mcu_write(2'd3, 8'h99);
    main_rd = 1'b1;
    rst = 1'b1;
    idle(2);
    model_reset();
    check("rst_sec2", 32'(sec2), 32'h0);
    check("rst_intn", 32'(mcu_intn), 32'h1);
    check("rst_dout", 32'(mcu_dout), 32'h0);
    check("rst_mcu_q", 32'(mcu_q), 32'h0);
    rst = 1'b0;
    mcu_write(2'd3, 8'h22);
    idle(4);
    check("no_rd_event_after_rst", 32'(sec2), 32'h1);
    main_rd = 1'b0;
    idle(2);
    main_read(1);
    check("sec2_after_rst_read", 32'(sec2), 32'h0);

    // Unread reply: times out with the macro, held indefinitely without it.
    mcu_write(2'd3, 8'h44);
    cnt = 0;
`ifdef JTCOP_MCU_TIMEOUT_EN
    while (sec2 && cnt < 40) begin
      cnt++;
      idle(1);
    end
    check("timeout_cycles", 32'(cnt), 32'd16);
    m_raised = 0;
    m_ovr    = 1;
    mcu_read(2'd2);
`else
    repeat (1000) begin
      if (sec2) cnt++;
      idle(1);
    end
    check("sec2_held_1000", 32'(cnt), 32'd1000);
    main_read(1);
`endif

    // Randomized traffic against the model.
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 4))
        0: main_write(16'($urandom), int'($urandom_range(1, 4)));
        1: mcu_read(2'($urandom_range(0, 3)));
        2: mcu_write(2'd2, 8'($urandom));
        3: begin
          if (!m_raised) begin
            mcu_write(2'd3, 8'($urandom));
`ifdef JTCOP_MCU_TIMEOUT_EN
            main_read(1);
`endif
          end else begin
            main_read(int'($urandom_range(1, 3)));
          end
        end
        default: main_read(int'($urandom_range(1, 3)));
      endcase
    end

    idle(5);
    check("reads_drained", 32'(exp_q.size()), 32'd0);
    check("replies_drained", 32'(rep_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
